// File: rtl/seg_disp_ctrl.sv
// Seven-segment display controller: two-requester round-robin arbiter,
// double-dabble BCD engine, display formatter and minimum dwell timer.
module seg_disp_ctrl #(
    parameter int HOLD_CYC = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_on,
    input  logic        a_valid,
    input  logic [13:0] a_value,
    input  logic [1:0]  a_dp,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [13:0] b_value,
    input  logic [1:0]  b_dp,
    output logic        b_ready,
    output logic [15:0] bcd,
    output logic        frac,
    output logic [3:0]  dp,
    output logic        en,
    output logic        ovf,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CONV, FMT, HOLD} state_t;

    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    step;
    logic [29:0]   sr;
    logic [29:0]   sr_adj;
    logic          neg_q;
    logic          ovf_q;
    logic [1:0]    dp_q;
    logic          last_b;
    logic          shown;

    logic          grant_a;
    logic          grant_b;
    logic [13:0]   sel_value;
    logic [1:0]    sel_dp;
    logic [13:0]   sel_mag;
    logic          sel_ovf;
    logic [15:0]   fmt_bcd;
    logic [3:0]    fmt_dp;
    int            hi;
    int            top;

    // Contention goes to whoever was not served last
    assign grant_a = a_valid & (~b_valid | last_b);
    assign grant_b = b_valid & (~a_valid | ~last_b);

    assign sel_value = grant_b ? b_value : a_value;
    assign sel_dp    = grant_b ? b_dp : a_dp;
    assign sel_mag   = sel_value[13] ? -sel_value : sel_value;
    assign sel_ovf   = sel_value[13] &
                       ((sel_mag > 14'd999) | (sel_dp == 2'd3));

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        unique case (state)
            IDLE: begin
                a_ready = grant_a;
                b_ready = grant_b;
                if (grant_a || grant_b)
                    state_nxt = CONV;
            end
            CONV: begin
                if (step == 4'd13)
                    state_nxt = FMT;
            end
            FMT: state_nxt = HOLD;
            HOLD: begin
                if (cnt == CW'(HOLD_CYC - 1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble before the shift
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 4; i++) begin
            if (sr[14+4*i +: 4] >= 4'd5)
                sr_adj[14+4*i +: 4] = sr[14+4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        hi = 0;
        for (int i = 1; i < 4; i++) begin
            if (sr[14+4*i +: 4] != 4'd0)
                hi = i;
        end
        top = (int'(dp_q) > hi) ? int'(dp_q) : hi;
        fmt_bcd = '0;
        for (int i = 0; i < 4; i++) begin
            if (i <= top)
                fmt_bcd[4*i +: 4] = sr[14+4*i +: 4];
            else if (neg_q && i == top + 1)
                fmt_bcd[4*i +: 4] = 4'd11;
            else
                fmt_bcd[4*i +: 4] = 4'd10;
        end
        fmt_dp = (dp_q == 2'd0) ? 4'd0 : (4'b0001 << dp_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr     <= '0;
            step   <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            dp_q   <= 2'd0;
            last_b <= 1'b1;
            shown  <= 1'b0;
            bcd    <= 16'hAAAA;
            frac   <= 1'b0;
            dp     <= 4'd0;
            ovf    <= 1'b0;
            en     <= 1'b0;
        end else begin
            en <= disp_on & shown;
            unique case (state)
                IDLE: begin
                    if (a_ready || b_ready) begin
                        sr     <= {16'd0, sel_mag};
                        step   <= 4'd0;
                        neg_q  <= sel_value[13];
                        ovf_q  <= sel_ovf;
                        dp_q   <= sel_dp;
                        last_b <= b_ready;
                    end
                end
                CONV: begin
                    sr   <= sr_adj << 1;
                    step <= step + 4'd1;
                end
                FMT: begin
                    if (ovf_q) begin
                        bcd  <= 16'hBBBB;
                        frac <= 1'b0;
                        dp   <= 4'd0;
                        ovf  <= 1'b1;
                    end else begin
                        bcd  <= fmt_bcd;
                        frac <= (dp_q != 2'd0);
                        dp   <= fmt_dp;
                        ovf  <= 1'b0;
                    end
                    shown <= 1'b1;
                    cnt   <= '0;
                end
                HOLD: cnt <= cnt + CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Self-checking bench for seg_disp_ctrl: vector table, random traffic
// against a decimal reference model, arbitration and reset sequences.
module tb_seg_disp_ctrl;

    localparam int HC = 4;

    typedef struct packed {
        logic [15:0] bcd;
        logic        frac;
        logic [3:0]  dp;
        logic        ovf;
    } disp_t;

    typedef struct packed {
        logic [13:0] value;
        logic [1:0]  dpi;
        disp_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_on;
    logic        a_valid, b_valid;
    logic [13:0] a_value, b_value;
    logic [1:0]  a_dp, b_dp;
    logic        a_ready, b_ready;
    logic [15:0] bcd;
    logic        frac;
    logic [3:0]  dp;
    logic        en, ovf, busy;

    int n_chk = 0;
    int n_fail = 0;

    seg_disp_ctrl #(.HOLD_CYC(HC)) dut (
        .clk(clk), .rst_n(rst_n), .disp_on(disp_on),
        .a_valid(a_valid), .a_value(a_value), .a_dp(a_dp), .a_ready(a_ready),
        .b_valid(b_valid), .b_value(b_value), .b_dp(b_dp), .b_ready(b_ready),
        .bcd(bcd), .frac(frac), .dp(dp), .en(en), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Decimal model: the number occupies as many digit positions as it
    // needs (at least up to the dp digit), a minus sits just left of it.
    function automatic disp_t ref_disp(input logic [13:0] v, input logic [1:0] d);
        int sv;
        int mag;
        int width;
        int q;
        int code[4];
        disp_t r;
        sv  = int'($signed(v));
        mag = (sv < 0) ? -sv : sv;
        if (sv < 0 && (mag > 999 || d == 2'd3)) begin
            r.bcd = 16'hBBBB; r.frac = 1'b0; r.dp = 4'd0; r.ovf = 1'b1;
            return r;
        end
        width = (mag >= 1000) ? 4 : (mag >= 100) ? 3 : (mag >= 10) ? 2 : 1;
        if (int'(d) + 1 > width) width = int'(d) + 1;
        q = mag;
        for (int i = 0; i < 4; i++) begin
            if (i < width) code[i] = q % 10;
            else if (i == width && sv < 0) code[i] = 11;
            else code[i] = 10;
            q = q / 10;
        end
        r.bcd  = {4'(code[3]), 4'(code[2]), 4'(code[1]), 4'(code[0])};
        r.frac = (d != 2'd0);
        r.dp   = (d == 2'd0) ? 4'd0 : 4'(1 << d);
        r.ovf  = 1'b0;
        return r;
    endfunction

    function automatic vec_t mk(input int value, input int d, input logic [15:0] b,
                                input logic f, input logic [3:0] p, input logic o);
        vec_t t;
        t.value = 14'(value);
        t.dpi = 2'(d);
        t.exp.bcd = b; t.exp.frac = f; t.exp.dp = p; t.exp.ovf = o;
        return t;
    endfunction

    task automatic drive(input bit use_b, input bit vld,
                         input logic [13:0] v, input logic [1:0] d);
        if (use_b) begin b_valid = vld; b_value = v; b_dp = d; end
        else begin a_valid = vld; a_value = v; a_dp = d; end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    // One request from ready through E16; with jitter the value changes
    // every cycle until the accept, and the sampled value is expected.
    task automatic transact(input bit use_b, input logic [13:0] v_in,
                            input logic [1:0] d, input bit jitter,
                            input bit has_exp, input disp_t exp_in,
                            input bit first);
        int waited = 0;
        logic rdy;
        logic [13:0] v;
        logic [15:0] prev;
        disp_t e;
        v = v_in;
        @(negedge clk);
        drive(use_b, 1'b1, v, d);
        #1 rdy = use_b ? b_ready : a_ready;
        while (!rdy && waited < 200) begin
            @(negedge clk);
            waited++;
            if (jitter) begin
                v = 14'($urandom);
                drive(use_b, 1'b1, v, d);
            end
            #1 rdy = use_b ? b_ready : a_ready;
        end
        chk("ready_seen", rdy, 1);
        if (!rdy) begin
            drive(use_b, 1'b0, v, d);
            return;
        end
        chk("other_ready", use_b ? a_ready : b_ready, 0);
        e = has_exp ? exp_in : ref_disp(v, d);
        prev = bcd;
        @(posedge clk);
        #1 drive(use_b, 1'b0, 14'd0, 2'd0);
        chk("busy_after_e0", busy, 1);
        chk("ready_after_e0", a_ready | b_ready, 0);
        repeat (14) @(posedge clk);
        #1 chk("bcd_before_e15", bcd, prev);
        @(posedge clk);
        #1;
        chk("bcd", bcd, e.bcd);
        chk("frac", frac, e.frac);
        chk("dp", dp, e.dp);
        chk("ovf", ovf, e.ovf);
        if (first) chk("en_at_e15", en, 0);
        @(posedge clk);
        #1 chk("en_at_e16", en, disp_on);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        logic [15:0] held;
        int last_acc;
        int n_acc;
        int rnd;
        logic exp_busy;
        logic exp_rdy;
        logic [13:0] rv;

        rst_n = 1'b0; disp_on = 1'b1;
        a_valid = 0; a_value = 0; a_dp = 0;
        b_valid = 0; b_value = 0; b_dp = 0;

        tbl[0]  = mk(1234,  0, 16'h1234, 0, 4'b0000, 0);
        tbl[1]  = mk(-5,    0, 16'hAAB5, 0, 4'b0000, 0);
        tbl[2]  = mk(-5,    2, 16'hB005, 1, 4'b0100, 0);
        tbl[3]  = mk(0,     0, 16'hAAA0, 0, 4'b0000, 0);
        tbl[4]  = mk(8191,  0, 16'h8191, 0, 4'b0000, 0);
        tbl[5]  = mk(-999,  0, 16'hB999, 0, 4'b0000, 0);
        tbl[6]  = mk(-8192, 0, 16'hBBBB, 0, 4'b0000, 1);
        tbl[7]  = mk(5,     3, 16'h0005, 1, 4'b1000, 0);
        tbl[8]  = mk(-12,   1, 16'hAB12, 1, 4'b0010, 0);
        tbl[9]  = mk(-1000, 0, 16'hBBBB, 0, 4'b0000, 1);
        tbl[10] = mk(-5,    3, 16'hBBBB, 0, 4'b0000, 1);
        tbl[11] = mk(42,    0, 16'hAA42, 0, 4'b0000, 0);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_bcd", bcd, 16'hAAAA);
        chk("rst_frac", frac, 0);
        chk("rst_dp", dp, 0);
        chk("rst_en", en, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            transact(1'b0, tbl[i].value, tbl[i].dpi, 1'b0, 1'b1, tbl[i].exp, i == 0);
        wait_idle();

        // disp_on drop blanks the driver but keeps the digits
        @(negedge clk);
        disp_on = 1'b0;
        held = bcd;
        #1 chk("en_before_drop", en, 1);
        @(posedge clk);
        #1;
        chk("en_dropped", en, 0);
        chk("bcd_held", bcd, held);
        @(negedge clk);
        disp_on = 1'b1;
        @(posedge clk);
        #1 chk("en_restored", en, 1);

        disp_on = 1'b0;
        transact(1'b1, 14'd567, 2'd1, 1'b0, 1'b0, '0, 1'b0);
        wait_idle();
        disp_on = 1'b1;

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                rv = 14'($urandom);
            end else begin
                rnd = int'($urandom_range(0, 1999)) - 1000;
                rv = 14'(rnd);
            end
            transact(1'($urandom_range(0, 1)), rv, 2'($urandom_range(0, 3)),
                     1'b1, 1'b0, '0, 1'b0);
        end
        wait_idle();

        // Contention from reset: A, B, A, B every 16+HOLD_CYC cycles
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, 14'd11, 2'd0);
        drive(1'b1, 1'b1, 14'd22, 2'd0);
        last_acc = -1;
        n_acc = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            #1;
            exp_busy = (last_acc >= 0) && (cyc - last_acc >= 1) &&
                       (cyc - last_acc <= 15 + HC);
            exp_rdy = (last_acc < 0) || (cyc - last_acc == 16 + HC);
            chk("arb_busy", busy, exp_busy);
            chk("arb_ready", a_ready | b_ready, exp_rdy);
            chk("arb_excl", a_ready & b_ready, 0);
            chk("arb_ready_busy", (a_ready | b_ready) & busy, 0);
            if (a_ready | b_ready) begin
                chk("arb_order", b_ready, n_acc % 2);
                if (last_acc >= 0) chk("arb_spacing", cyc - last_acc, 16 + HC);
                last_acc = cyc;
                n_acc++;
            end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 14'd0, 2'd0);
        drive(1'b1, 1'b0, 14'd0, 2'd0);
        chk("arb_count", n_acc, 4);
        wait_idle();
        chk("arb_last_bcd", bcd, 16'hAA22);

        // Reset in the middle of a conversion
        @(negedge clk);
        drive(1'b0, 1'b1, 14'd77, 2'd1);
        #1 chk("rc_ready", a_ready, 1);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 14'd0, 2'd0);
        repeat (4) @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rc_bcd", bcd, 16'hAAAA);
        chk("rc_frac", frac, 0);
        chk("rc_dp", dp, 0);
        chk("rc_en", en, 0);
        chk("rc_ovf", ovf, 0);
        chk("rc_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        transact(1'b0, 14'd321, 2'd0, 1'b0, 1'b0, '0, 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_disp_ctrl.md
# seg_disp_ctrl

Display controller and arbiter for the 4-digit seven-segment driver. It shares the display between two requesters (A and B) through valid/ready handshakes with round-robin arbitration. Each accepted signed binary value is converted to BCD by a sequential shift-add-3 engine. The result is formatted with leading-zero blanking, a minus sign, decimal-point placement and overflow indication, then held on the driver inputs (`bcd`, `frac`, `dp`, `en`) for a minimum dwell time.

## Interface
- `HOLD_CYC`, default 5_000_000: minimum dwell after each update, in clk cycles; legal range ≥1. The counter width is derived from it.
- Reset is `rst_n`, asynchronous, active-low; clock is `clk`.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `disp_on` input 1: display enable request.
- `a_valid` input 1: requester A has a value.
- `a_value` input 14: requester A value, signed two's complement.
- `a_dp` input 2: requester A decimal-point digit index; 0 means none, 1..3 light the dp of that digit.
- `a_ready` output 1: A accepted this cycle.
- `b_valid`, `b_value`, `b_dp`, `b_ready`: same as A, for requester B.
- `bcd` output 16: digit codes, d3 in [15:12] … d0 in [3:0]. Codes 0–9 are digits, 10 is blank, 11 is minus.
- `frac` output 1: decimal point present.
- `dp` output 4: one-hot decimal-point position.
- `en` output 1: driver enable.
- `ovf` output 1: the currently displayed value overflowed.
- `busy` output 1: state ≠ IDLE.

## Operation
- **States:** IDLE, CONV, FMT, HOLD.
- **IDLE:**
  - grant = the only valid requester. If both are valid, grant the one not served last.
  - `x_ready` = (state==IDLE) & grant_x. This is combinational from valid.
  - On `valid & ready`: latch value and dp, record the served requester, go to CONV.
- **Sign handling at accept:**
  - neg = value[13]; mag = |value|.
  - If neg and (mag > 999 or dp == 3), set the overflow flag.
- **CONV:**
  - 14 cycles of double-dabble over mag: add 3 to any BCD nibble ≥5, then shift left one bit.
  - Maximum mag is 8192, so 4 nibbles suffice.
  - Then go to FMT.
- **FMT (1 cycle):** register the outputs, then go to HOLD.
  - Overflow: `bcd` = 16'hBBBB, `frac` = 0, `dp` = 0, `ovf` = 1.
  - Otherwise compute m = max(index of highest nonzero digit, dp index, 0).
    - Digits above m get code 10 (blank).
    - If neg, digit m+1 gets code 11 (minus).
    - `dp` = one-hot(dp index) if dp ≠ 0, else 0.
    - `frac` = (dp ≠ 0).
    - `ovf` = 0.
  - Set the internal shown flag.
- **HOLD:** count HOLD_CYC cycles, then go to IDLE. Requests are not accepted while in HOLD.
- **`en`:** registered, `en <= disp_on & shown`. Dropping `disp_on` blanks the display but does not stop sequencing; `bcd` keeps its value.
- **Round-robin pointer reset value:** "last served = B", so A wins the first contention.

## Timing
- **Reset values:** `bcd` = 16'hAAAA, `frac` = 0, `dp` = 0, `en` = 0, `ovf` = 0, `busy` = 0, `a_ready` = 0, `b_ready` = 0, state IDLE, shown = 0.
- **Latency:**
  - Let the accept edge be E0.
  - CONV occupies edges E1–E14.
  - FMT registers the outputs at E15.
  - `en` rises at E16 if `disp_on` = 1.
- **Throughput:**
  - HOLD occupies E16 through E15+HOLD_CYC.
  - The next accept is possible at E16+HOLD_CYC, giving a request spacing of 16+HOLD_CYC cycles.
- **`busy`:** high from the cycle after E0 until HOLD exits.
- **Ready rules:**
  - `ready` is never asserted outside IDLE.
  - At most one `ready` is asserted per cycle.
  - A requester must hold valid and data stable until its ready.
- **Reset mid-operation:** all outputs return to reset values immediately. The conversion is discarded; no partial `bcd` update.
- **Value change while valid:** a change before accept is legal; the value sampled at E0 is used.

## Test plan
- **Basic conversion:** after reset, A: value 1234, dp 0 → `a_ready` at E0; `bcd` = 16'h1234, `frac` = 0 at E15; `en` = 1 at E16.
- **Blanking and sign:**
  - A: −5, dp 0 → `bcd` = 16'hAAB5.
  - A: −5, dp 2 → `bcd` = 16'hB005, `dp` = 4'b0100, `frac` = 1.
  - 0, dp 0 → 16'hAAA0.
  - 8191 → 16'h8191.
- **Overflow:**
  - −1000, dp 0 → `bcd` = 16'hBBBB, `ovf` = 1, `frac` = 0, `dp` = 0.
  - −5, dp 3 → same result.
  - A following valid 42 → `ovf` = 0, `bcd` = 16'hAA42.
- **Arbitration** (HOLD_CYC = 4, A and B valid continuously):
  - Grants go A, B, A, B.
  - Accepts are exactly 20 cycles apart.
  - No ready is asserted during CONV, FMT or HOLD.
  - `busy` matches.
- **Reset during CONV:** assert `rst_n` low at E5.
  - All outputs go to reset values immediately.
  - After release, a new request completes normally in 15 cycles.
- **`disp_on` = 0 mid-display:** `en` falls one cycle later while `bcd` holds. Setting `disp_on` = 1 restores `en` one cycle later.
